dmem_clock_responder: RTL and testbench

Data-memory responder for the single-cycle RV32 core: it serves the core's data port (address, write data, write enable, read data) with a word RAM plus a memory-mapped time-of-day clock peripheral. It answers loads combinationally in the same cycle, because the core has no stall path. Stores commit on the rising clock edge. The clock peripheral keeps hours/minutes/seconds from a programmable prescaler and drives display outputs.

---
 rtl/dmem_clock_responder_pkg.sv | 41 ++++
 rtl/dmem_clock_responder_tod_counter.sv | 115 +++++++++++
 rtl/dmem_clock_responder.sv | 128 ++++++++++++
 tb/tb_dmem_clock_responder.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_clock_responder_pkg.sv
// dmem_clock_responder_pkg
// Shared definitions for the data-memory responder and its time-of-day
// counter: peripheral register offsets (word index within the MMIO block),
// time field widths and limits, and the range-checked load helpers used
// when software writes a time field.
package dmem_clock_responder_pkg;

    // Word index of each register inside the 32-byte peripheral block (Addr[4:2]).
    typedef enum logic [2:0] {
        REG_CTRL     = 3'd0,
        REG_SEC      = 3'd1,
        REG_MIN      = 3'd2,
        REG_HOUR     = 3'd3,
        REG_PRESCALE = 3'd4,
        REG_CYCLES   = 3'd5,
        REG_RSVD6    = 3'd6,
        REG_RSVD7    = 3'd7
    } mmio_reg_e;

    // Number of low address bits spanned by the peripheral block.
    localparam int MMIO_SPAN_W = 5;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;

    // The whole store word is range-checked, so e.g. 75 loads 0 rather than
    // its low six bits.
    function automatic logic [SEC_W-1:0] load_sexagesimal(input logic [31:0] v);
        return (v > 32'(SEC_MAX)) ? '0 : v[SEC_W-1:0];
    endfunction

    function automatic logic [HOUR_W-1:0] load_hour(input logic [31:0] v);
        return (v > 32'(HOUR_MAX)) ? '0 : v[HOUR_W-1:0];
    endfunction

endpackage

// File: rtl/dmem_clock_responder_tod_counter.sv
// tod_counter
// Time-of-day counter: a programmable prescaler that produces one
// second-tick every PRESCALE+1 running clocks, the HH:MM:SS carry chain,
// and a one-cycle tick_o pulse in the cycle after the seconds advanced.
//
// Ports:
//   clk, reset       clock, asynchronous active-high reset
//   run_i            RUN bit from CTRL (registered)
//   stop_i           CTRL store clearing RUN this cycle; cancels a due tick
//   prescale_we_i    load PRESCALE from wdata_i, clear prescaler count
//   sec_we_i/min_we_i/hour_we_i
//                    load the time field (out-of-range loads 0), clear the
//                    prescaler count and suppress any tick this cycle
//   wdata_i          store data
//   prescale_o       current PRESCALE value (for read-back)
//   sec_o/min_o/hour_o registered time fields
//   tick_o           one-cycle pulse after a second advanced
module tod_counter
    import dmem_clock_responder_pkg::*;
#(
    parameter logic [31:0] PRESCALE_RST = 32'd49
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_i,
    input  logic              stop_i,
    input  logic              prescale_we_i,
    input  logic              sec_we_i,
    input  logic              min_we_i,
    input  logic              hour_we_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       prescale_o,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [HOUR_W-1:0] hour_o,
    output logic              tick_o
);

    logic [31:0]       prescale_q, prescale_d;
    logic [31:0]       count_q,    count_d;
    logic [SEC_W-1:0]  sec_q,      sec_d;
    logic [MIN_W-1:0]  min_q,      min_d;
    logic [HOUR_W-1:0] hour_q,     hour_d;
    logic              tick_q,     tick_d;

    logic time_we;
    logic counting;
    logic tick_due;

    always_comb begin
        prescale_d = prescale_q;
        count_d    = count_q;
        sec_d      = sec_q;
        min_d      = min_q;
        hour_d     = hour_q;
        tick_d     = 1'b0;

        time_we  = sec_we_i | min_we_i | hour_we_i;
        // A store that clears RUN freezes the prescaler in that same cycle.
        counting = run_i & ~stop_i;
        // Any register load takes priority over a tick that would land now.
        tick_due = counting & (count_q == prescale_q) & ~time_we & ~prescale_we_i;

        if (prescale_we_i) begin
            prescale_d = wdata_i;
            count_d    = '0;
        end else if (time_we) begin
            count_d = '0;
            if (sec_we_i)  sec_d  = load_sexagesimal(wdata_i);
            if (min_we_i)  min_d  = load_sexagesimal(wdata_i);
            if (hour_we_i) hour_d = load_hour(wdata_i);
        end else if (tick_due) begin
            count_d = '0;
            tick_d  = 1'b1;
            if (sec_q == SEC_MAX) begin
                sec_d = '0;
                if (min_q == MIN_MAX) begin
                    min_d  = '0;
                    hour_d = (hour_q == HOUR_MAX) ? '0 : hour_q + 1'b1;
                end else begin
                    min_d = min_q + 1'b1;
                end
            end else begin
                sec_d = sec_q + 1'b1;
            end
        end else if (counting) begin
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prescale_q <= PRESCALE_RST;
            count_q    <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            tick_q     <= 1'b0;
        end else begin
            prescale_q <= prescale_d;
            count_q    <= count_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            tick_q     <= tick_d;
        end
    end

    assign prescale_o = prescale_q;
    assign sec_o      = sec_q;
    assign min_o      = min_q;
    assign hour_o     = hour_q;
    assign tick_o     = tick_q;

endmodule

// File: rtl/dmem_clock_responder.sv
// dmem_clock_responder
// Data-memory responder for a single-cycle RV32 core. Loads are answered
// combinationally from Addr in the same cycle (the core cannot stall);
// stores commit on the rising clock edge. Address space: a word RAM from
// address 0 and a 32-byte peripheral block at MMIO_BASE holding CTRL,
// the time-of-day registers, PRESCALE and a free-running CYCLES counter.
//
// Ports:
//   clk, reset          core clock, asynchronous active-high reset
//   Addr                byte address (low two bits ignored)
//   WriteData, MemWrite store data and enable
//   ReadData            combinational load data; 0 for unmapped addresses
//   sec_o/min_o/hour_o  current time fields
//   tick_o              one-cycle pulse after the seconds advanced
module dmem_clock_responder
    import dmem_clock_responder_pkg::*;
#(
    parameter int          RAM_WORDS    = 64,
    parameter logic [31:0] MMIO_BASE    = 32'h0000_1000,
    parameter logic [31:0] PRESCALE_RST = 32'd49
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       Addr,
    input  logic [31:0]       WriteData,
    input  logic              MemWrite,
    output logic [31:0]       ReadData,
    output logic [SEC_W-1:0]  sec_o,
    output logic [MIN_W-1:0]  min_o,
    output logic [HOUR_W-1:0] hour_o,
    output logic              tick_o
);

    localparam int          RAM_AW    = $clog2(RAM_WORDS);
    localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

    logic [31:0] ram_q [RAM_WORDS];

    logic              ram_hit;
    logic              mmio_hit;
    mmio_reg_e         reg_sel;
    logic [RAM_AW-1:0] ram_idx;

    logic ctrl_we, sec_we, min_we, hour_we, prescale_we;
    logic stop_req;

    logic        run_q,    run_d;
    logic [31:0] cycles_q, cycles_d;
    logic [31:0] prescale;

    // Address decode; the RAM check compares the full address so anything
    // past the last word is unmapped rather than aliasing back onto RAM.
    always_comb begin
        ram_hit  = (Addr < RAM_BYTES);
        mmio_hit = (Addr[31:MMIO_SPAN_W] == MMIO_BASE[31:MMIO_SPAN_W]);
        reg_sel  = mmio_reg_e'(Addr[4:2]);
        ram_idx  = Addr[RAM_AW+1:2];
    end

    always_comb begin
        ctrl_we     = MemWrite & mmio_hit & (reg_sel == REG_CTRL);
        sec_we      = MemWrite & mmio_hit & (reg_sel == REG_SEC);
        min_we      = MemWrite & mmio_hit & (reg_sel == REG_MIN);
        hour_we     = MemWrite & mmio_hit & (reg_sel == REG_HOUR);
        prescale_we = MemWrite & mmio_hit & (reg_sel == REG_PRESCALE);
        stop_req    = ctrl_we & ~WriteData[0];
    end

    always_comb begin
        run_d    = ctrl_we ? WriteData[0] : run_q;
        cycles_d = cycles_q + 32'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q    <= 1'b0;
            cycles_q <= '0;
        end else begin
            run_q    <= run_d;
            cycles_q <= cycles_d;
        end
    end

    // RAM contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (MemWrite && ram_hit) begin
            ram_q[ram_idx] <= WriteData;
        end
    end

    tod_counter #(
        .PRESCALE_RST (PRESCALE_RST)
    ) u_tod (
        .clk           (clk),
        .reset         (reset),
        .run_i         (run_q),
        .stop_i        (stop_req),
        .prescale_we_i (prescale_we),
        .sec_we_i      (sec_we),
        .min_we_i      (min_we),
        .hour_we_i     (hour_we),
        .wdata_i       (WriteData),
        .prescale_o    (prescale),
        .sec_o         (sec_o),
        .min_o         (min_o),
        .hour_o        (hour_o),
        .tick_o        (tick_o)
    );

    // Load path reads pre-edge state, so a same-cycle store is not visible.
    always_comb begin
        ReadData = '0;
        if (ram_hit) begin
            ReadData = ram_q[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                REG_CTRL:     ReadData = {31'b0, run_q};
                REG_SEC:      ReadData = {{(32-SEC_W){1'b0}}, sec_o};
                REG_MIN:      ReadData = {{(32-MIN_W){1'b0}}, min_o};
                REG_HOUR:     ReadData = {{(32-HOUR_W){1'b0}}, hour_o};
                REG_PRESCALE: ReadData = prescale;
                REG_CYCLES:   ReadData = cycles_q;
                default:      ReadData = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_clock_responder.sv
module tb_dmem_clock_responder;

    localparam logic [31:0] BASE       = 32'h0000_1000;
    localparam logic [31:0] A_CTRL     = BASE + 32'h00;
    localparam logic [31:0] A_SEC      = BASE + 32'h04;
    localparam logic [31:0] A_MIN      = BASE + 32'h08;
    localparam logic [31:0] A_HOUR     = BASE + 32'h0C;
    localparam logic [31:0] A_PRESCALE = BASE + 32'h10;
    localparam logic [31:0] A_CYCLES   = BASE + 32'h14;
    localparam logic [31:0] A_RSVD     = BASE + 32'h18;

    localparam int SEL_RD   = 0;
    localparam int SEL_SEC  = 1;
    localparam int SEL_MIN  = 2;
    localparam int SEL_HOUR = 3;
    localparam int SEL_TICK = 4;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [5:0]  sec_o;
    logic [5:0]  min_o;
    logic [4:0]  hour_o;
    logic        tick_o;

    dmem_clock_responder #(
        .RAM_WORDS    (64),
        .MMIO_BASE    (32'h0000_1000),
        .PRESCALE_RST (32'd49)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Addr      (Addr),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .sec_o     (sec_o),
        .min_o     (min_o),
        .hour_o    (hour_o),
        .tick_o    (tick_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sb_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;

    // Reference model of CYCLES: clock edges seen outside reset.
    logic [31:0] tb_cycles;
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cycles <= 32'd0;
        else       tb_cycles <= tb_cycles + 32'd1;
    end

    // Monitor: outputs are stable mid-cycle; consume every pending expectation.
    always @(negedge clk) begin
        while (sb_q.size() > 0) begin
            item_t       it;
            logic [31:0] act;
            it = sb_q.pop_front();
            case (it.sel)
                SEL_RD:   act = ReadData;
                SEL_SEC:  act = {26'b0, sec_o};
                SEL_MIN:  act = {26'b0, min_o};
                SEL_HOUR: act = {27'b0, hour_o};
                default:  act = {31'b0, tick_o};
            endcase
            n_tests++;
            if (act !== it.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h, expected 0x%08h", it.name, act, it.exp);
            end
        end
    end

    function automatic void push(input string n, input int sel, input logic [31:0] e);
        item_t it;
        it.name = n;
        it.sel  = sel;
        it.exp  = e;
        sb_q.push_back(it);
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        Addr     = a;
        MemWrite = 1'b0;
        push(n, SEL_RD, e);
        step(1);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        step(1);
        MemWrite  = 1'b0;
    endtask

    // Store and load the same address in one cycle: load must see old data.
    task automatic wr_rd_old(input logic [31:0] a, input logic [31:0] d,
                             input logic [31:0] e, input string n);
        Addr      = a;
        WriteData = d;
        MemWrite  = 1'b1;
        push(n, SEL_RD, e);
        step(1);
        MemWrite  = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        Addr      = 32'h0;
        WriteData = 32'h0;
        MemWrite  = 1'b0;
        step(1);

        // Reset state
        push("rst_sec",  SEL_SEC,  32'd0);
        push("rst_min",  SEL_MIN,  32'd0);
        push("rst_hour", SEL_HOUR, 32'd0);
        push("rst_tick", SEL_TICK, 32'd0);
        rd(A_PRESCALE, 32'd49, "rst_prescale");
        rd(A_SEC,      32'd0,  "rst_sec_rd");
        rd(A_CTRL,     32'd0,  "rst_ctrl");
        reset = 1'b0;
        step(3);
        rd(A_CYCLES, 32'd3, "cycles_after_3");

        // RAM
        wr(32'h20, 32'hDEAD_BEEF);
        rd(32'h20, 32'hDEAD_BEEF, "ram_0x20");
        rd(32'h23, 32'hDEAD_BEEF, "ram_0x23");
        wr(32'h2000, 32'h5555_5555);
        rd(32'h2000, 32'h0, "unmapped_0x2000");
        wr(32'h0, 32'h1111_1111);
        wr(32'h100, 32'hA5A5_A5A5);
        rd(32'h0,   32'h1111_1111, "ram_no_alias");
        rd(32'h100, 32'h0, "ram_end_unmapped");
        wr_rd_old(32'h20, 32'h1234_5678, 32'hDEAD_BEEF, "same_cycle_old");
        rd(32'h20, 32'h1234_5678, "ram_new");
        rd(A_RSVD, 32'h0, "mmio_rsvd");

        // Full rollover at 23:59:59 with a tick every clock
        wr(A_PRESCALE, 32'd0);
        wr(A_HOUR, 32'd23);
        wr(A_MIN,  32'd59);
        wr(A_SEC,  32'd59);
        wr(A_CTRL, 32'd1);
        push("pre_roll_sec",  SEL_SEC,  32'd59);
        push("pre_roll_tick", SEL_TICK, 32'd0);
        step(1);
        push("roll_sec",  SEL_SEC,  32'd0);
        push("roll_min",  SEL_MIN,  32'd0);
        push("roll_hour", SEL_HOUR, 32'd0);
        push("roll_tick", SEL_TICK, 32'd1);
        wr(A_CTRL, 32'd0);
        push("stop_wins_tick", SEL_TICK, 32'd0);
        push("stop_wins_sec",  SEL_SEC,  32'd0);
        rd(A_CTRL, 32'd0, "ctrl_stopped");
        rd(A_HOUR, 32'd0, "roll_hour_rd");

        // PRESCALE=3: one second every 4 clocks; SEC write on a tick cycle
        wr(A_PRESCALE, 32'd3);
        wr(A_CTRL, 32'd1);
        step(3);
        push("ps3_before", SEL_SEC, 32'd0);
        step(1);
        push("ps3_sec1",  SEL_SEC,  32'd1);
        push("ps3_tick1", SEL_TICK, 32'd1);
        step(3);
        push("ps3_hold",      SEL_SEC,  32'd1);
        push("ps3_tick_gone", SEL_TICK, 32'd0);
        wr(A_SEC, 32'd10);
        push("secwr_val",  SEL_SEC,  32'd10);
        push("secwr_tick", SEL_TICK, 32'd0);
        step(3);
        push("secwr_wait", SEL_SEC, 32'd10);
        step(1);
        push("secwr_next",      SEL_SEC,  32'd11);
        push("secwr_next_tick", SEL_TICK, 32'd1);
        rd(A_SEC, 32'd11, "secwr_next_rd");

        // Out-of-range loads and read-only CYCLES
        wr(A_CTRL, 32'd0);
        wr(A_SEC,  32'd75);
        wr(A_HOUR, 32'd30);
        wr(A_MIN,  32'd59);
        rd(A_SEC,  32'd0,  "sec_75");
        rd(A_HOUR, 32'd0,  "hour_30");
        rd(A_MIN,  32'd59, "min_59");
        wr(A_MIN,  32'd60);
        rd(A_MIN,  32'd0,  "min_60");
        wr(A_CYCLES, 32'd5);
        rd(A_CYCLES, tb_cycles, "cycles_ro");
        wr(A_CTRL, 32'h8000_0001);
        rd(A_CTRL, 32'd1, "ctrl_bit0_only");

        // Asynchronous reset mid-run
        wr(A_SEC, 32'd12);
        rd(A_SEC, 32'd12, "pre_reset_sec");
        Addr = A_SEC;
        #1;
        reset = 1'b1;
        push("async_rd_sec", SEL_RD,   32'd0);
        push("async_sec_o",  SEL_SEC,  32'd0);
        push("async_tick",   SEL_TICK, 32'd0);
        step(1);
        rd(A_PRESCALE, 32'd49, "async_prescale");
        reset = 1'b0;
        step(2);
        rd(A_CTRL, 32'd0, "post_reset_run");
        push("post_reset_sec", SEL_SEC, 32'd0);
        rd(A_CYCLES, tb_cycles, "post_reset_cycles");

        step(2);
        if (sb_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
